mdu: RTL and testbench
======================

Name: mdu

Overview:
- Multiply/divide unit with the HI/LO register pair for the MIPS CPU.
- Sits in the execute stage, directly downstream of the GRF: consumes the two GRF read ports (rs, rt) as operands.
- Its read-back output (mfhi/mflo) returns to the GRF write-data mux.
- Multi-cycle; exposes busy so the hazard unit can stall dependent MDU instructions.

Parameters:
- MULT_CYCLES, 5, cycles busy is held after a mult/multu start.
- DIV_CYCLES, 10, cycles busy is held after a div/divu start.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  launch the operation on op; sampled on the rising edge.
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 reserved (no effect).
- A  input  32  operand rs (GRF RD1).
- B  input  32  operand rt (GRF RD2).
- rd_sel  input  1  0 selects LO, 1 selects HI on out.
- busy  output  1  an operation is in flight.
- HI  output  32  HI register.
- LO  output  32  LO register.
- out  output  32  combinational: rd_sel ? HI : LO.
- pc  input  32  instruction address, used only by the optional trace.

Behaviour:
- Reset (asynchronous, immediate): HI=0, LO=0, busy=0, counter=0, pending results cleared. Reset during an operation aborts it; no partial commit.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter counts down.
- IDLE with start and op in {0..3}:
  - Latch A, B and op; compute the 64-bit result into internal hi_n/lo_n at that edge.
  - counter = MULT_CYCLES (ops 0,1) or DIV_CYCLES (ops 2,3); go to RUN.
  - busy rises in the cycle after the start edge.
- RUN: counter decrements each edge. On the edge where the counter goes 1→0, HI=hi_n, LO=lo_n, busy=0, go to IDLE.
  - Total: a start at edge t commits at edge t+N; busy is high for exactly N cycles.
- IDLE with start and op=4/5: HI=A (op 4) or LO=A (op 5) at that edge; busy never asserts.
- start while busy=1: ignored entirely. The hazard unit guarantees this never happens; it is checked by assertion.
- Ops 6-7 with start: no state change.
- Arithmetic:
  - MULT: signed 32x32→64.
  - MULTU: unsigned 32x32→64.
  - HI = product[63:32], LO = product[31:0].
  - DIV/DIVU: LO = quotient truncated toward zero; HI = remainder. For DIV the remainder takes the sign of the dividend (A).
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (B=0, DIV or DIVU): runs the full DIV_CYCLES; HI/LO unchanged at commit.
- out and HI/LO reads are combinational. An mfhi/mflo issued while busy is stalled externally; the block gives no forwarding of pending results.

Optional Feature:
- Macro: MDU_TRACE_EN.
- Defined: every HI/LO write (commit, mthi, mtlo) prints a line in the GRF trace style:
  - "@<pc>: $hi <= <value>" and/or "@<pc>: $lo <= <value>".
  - Uses the pc latched at start, 8-digit hex.
  - Only when reset=0.
- Not defined: no $display; the pc input is unused.

Decomposition:
- Shared package mips_pkg: op encodings MDU_MULT..MDU_MTLO, default MULT_CYCLES/DIV_CYCLES constants.
- No sub-module. Counter, FSM and arithmetic are one process plus the combinational out mux; arithmetic uses the native * and / / % operators on 64-bit and signed casts.

Test Plan:
- MULT A=0xFFFFFFFE (-2), B=3, start at edge t -> busy high edges t+1..t+5; at edge t+5 HI=0xFFFFFFFF, LO=0xFFFFFFFA; busy=0.
- MULTU A=0xFFFFFFFF, B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7), B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=0 -> busy 10 cycles; HI/LO keep prior values.
- MTHI A=0x12345678, then MTLO A=0x9ABCDEF0 on consecutive edges -> HI/LO update at the same edge; busy stays 0; out follows rd_sel.
- DIV started, reset pulsed asynchronously mid-cycle at count 4 -> HI=LO=0 and busy=0 immediately; no commit afterwards.
- With MDU_TRACE_EN, MULT at pc=0x00003000 -> exactly one hi and one lo trace line at commit, showing @00003000.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS CPU definitions: MDU op encodings, default latencies and MDU FSM states.
package mips_pkg;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu.sv
// MIPS multiply/divide unit with HI/LO pair; results commit after a fixed latency.
// Optional trace of HI/LO writes is enabled by defining MDU_TRACE_EN.
module mdu
  import mips_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        rd_sel,
  input  logic [31:0] pc,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] out
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      hi_n_q, hi_n_d, lo_n_q, lo_n_d;
  logic             wr_q, wr_d;

  logic signed [63:0] sa, sb, sb_safe, prod_s, quot_s, rem_s;
  logic        [63:0] ua, ub, ub_safe, prod_u, quot_u, rem_u;

  // Divisor is forced to 1 on zero so the datapath never divides by zero;
  // the wr flag suppresses the commit in that case anyway.
  always_comb begin
    sa      = {{32{A[31]}}, A};
    sb      = {{32{B[31]}}, B};
    ua      = {32'd0, A};
    ub      = {32'd0, B};
    sb_safe = (B == 32'd0) ? 64'sd1 : sb;
    ub_safe = (B == 32'd0) ? 64'd1 : ub;
    prod_s  = sa * sb;
    prod_u  = ua * ub;
    quot_s  = sa / sb_safe;
    rem_s   = sa % sb_safe;
    quot_u  = ua / ub_safe;
    rem_u   = ua % ub_safe;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_n_d  = hi_n_q;
    lo_n_d  = lo_n_q;
    wr_d    = wr_q;
    unique case (state_q)
      MDU_IDLE: begin
        if (start) begin
          case (op)
            MDU_MULT, MDU_MULTU: begin
              {hi_n_d, lo_n_d} = (op == MDU_MULT) ? prod_s : prod_u;
              wr_d    = 1'b1;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = MDU_RUN;
            end
            MDU_DIV, MDU_DIVU: begin
              lo_n_d  = (op == MDU_DIV) ? quot_s[31:0] : quot_u[31:0];
              hi_n_d  = (op == MDU_DIV) ? rem_s[31:0]  : rem_u[31:0];
              wr_d    = (B != 32'd0);
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = MDU_RUN;
            end
            MDU_MTHI: hi_d = A;
            MDU_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      MDU_RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = MDU_IDLE;
          if (wr_q) begin
            hi_d = hi_n_q;
            lo_d = lo_n_q;
          end
        end
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; every register,
  // including the pending result, is cleared so a reset mid-operation commits nothing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      hi_n_q  <= '0;
      lo_n_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_n_q  <= hi_n_d;
      lo_n_q  <= lo_n_d;
      wr_q    <= wr_d;
    end
  end

  assign busy = (state_q == MDU_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;
  assign out  = rd_sel ? hi_q : lo_q;

  a_no_start_while_busy: assert property (@(posedge clk) disable iff (reset) !(start && busy));

`ifdef MDU_TRACE_EN
  logic [31:0] pc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= '0;
    end else if (state_q == MDU_IDLE && start && op <= 3'd3) begin
      pc_q <= pc;
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      if (state_q == MDU_RUN && cnt_q == CNT_W'(1) && wr_q) begin
        $display("@%08h: $hi <= %08h", pc_q, hi_n_q);
        $display("@%08h: $lo <= %08h", pc_q, lo_n_q);
      end else if (state_q == MDU_IDLE && start && op == MDU_MTHI) begin
        $display("@%08h: $hi <= %08h", pc, A);
      end else if (state_q == MDU_IDLE && start && op == MDU_MTLO) begin
        $display("@%08h: $lo <= %08h", pc, A);
      end
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc;
`endif

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases plus randomized ops against an arithmetic model.
module tb_mdu;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a_in, b_in, pc;
  logic        rd_sel;
  logic        busy;
  logic [31:0] hi_o, lo_o, out_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_hi, exp_lo;

  mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .A      (a_in),
    .B      (b_in),
    .rd_sel (rd_sel),
    .pc     (pc),
    .busy   (busy),
    .HI     (hi_o),
    .LO     (lo_o),
    .out    (out_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference: what HI/LO hold after the given op completes.
  task automatic model(input int o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sp, sq, sr;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      0: begin sp = sa * sb; exp_hi = sp[63:32]; exp_lo = sp[31:0]; end
      1: begin up = longint'(a) * longint'(b); exp_hi = up[63:32]; exp_lo = up[31:0]; end
      2: if (b != 0) begin sq = sa / sb; sr = sa % sb; exp_lo = sq[31:0]; exp_hi = sr[31:0]; end
      3: if (b != 0) begin exp_lo = a / b; exp_hi = a % b; end
      4: exp_hi = a;
      5: exp_lo = a;
      default: ;
    endcase
  endtask

  // Issue one op at the next edge and follow it until it has committed.
  task automatic do_op(input int o, input logic [31:0] a, input logic [31:0] b);
    int n;
    logic [31:0] pre_hi, pre_lo;
    pre_hi = exp_hi;
    pre_lo = exp_lo;
    n = (o < 2) ? MULT_N : (o < 4) ? DIV_N : 0;
    start = 1'b1; op = 3'(o); a_in = a; b_in = b; pc = pc + 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    model(o, a, b);
    if (n == 0) begin
      check($sformatf("busy_op%0d", o), {31'd0, busy}, 32'd0);
      check($sformatf("hi_op%0d", o), hi_o, exp_hi);
      check($sformatf("lo_op%0d", o), lo_o, exp_lo);
    end else begin
      check($sformatf("busy_rise_op%0d", o), {31'd0, busy}, 32'd1);
      check($sformatf("hi_hold_op%0d", o), hi_o, pre_hi);
      for (int k = 1; k <= n; k++) begin
        @(posedge clk); #1;
        if (k < n) begin
          check($sformatf("busy_mid_op%0d_k%0d", o, k), {31'd0, busy}, 32'd1);
        end else begin
          check($sformatf("busy_fall_op%0d", o), {31'd0, busy}, 32'd0);
          check($sformatf("hi_commit_op%0d", o), hi_o, exp_hi);
          check($sformatf("lo_commit_op%0d", o), lo_o, exp_lo);
        end
      end
    end
  endtask

  task automatic check_out();
    rd_sel = 1'b1; #1;
    check("out_hi", out_o, exp_hi);
    rd_sel = 1'b0; #1;
    check("out_lo", out_o, exp_lo);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; a_in = '0; b_in = '0; pc = 32'h0000_3000; rd_sel = 1'b0;
    exp_hi = '0; exp_lo = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_hi", hi_o, 32'd0);
    check("rst_lo", lo_o, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out", out_o, 32'd0);

    do_op(0, 32'hFFFF_FFFE, 32'd3);
    check("mult_hi_const", hi_o, 32'hFFFF_FFFF);
    check("mult_lo_const", lo_o, 32'hFFFF_FFFA);
    do_op(1, 32'hFFFF_FFFF, 32'd2);
    check("multu_hi_const", hi_o, 32'h0000_0001);
    check("multu_lo_const", lo_o, 32'hFFFF_FFFE);
    do_op(2, 32'hFFFF_FFF9, 32'd2);
    check("div_lo_const", lo_o, 32'hFFFF_FFFD);
    check("div_hi_const", hi_o, 32'hFFFF_FFFF);
    do_op(3, 32'd7, 32'd0);
    check("divu0_lo_kept", lo_o, 32'hFFFF_FFFD);
    do_op(2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_lo", lo_o, 32'h8000_0000);
    check("div_ovf_hi", hi_o, 32'h0000_0000);

    do_op(4, 32'h1234_5678, 32'd0);
    do_op(5, 32'h9ABC_DEF0, 32'd0);
    check("mthi_const", hi_o, 32'h1234_5678);
    check("mtlo_const", lo_o, 32'h9ABC_DEF0);
    check_out();
    do_op(6, 32'hDEAD_BEEF, 32'd1);
    do_op(7, 32'hCAFE_F00D, 32'd1);

    // Reset asynchronously mid-cycle while a divide has 4 counts left.
    start = 1'b1; op = 3'd3; a_in = 32'd100; b_in = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    exp_hi = '0; exp_lo = '0;
    check("arst_hi", hi_o, 32'd0);
    check("arst_lo", lo_o, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (DIV_N + 2) @(posedge clk);
    #1;
    check("arst_nocommit_hi", hi_o, 32'd0);
    check("arst_nocommit_lo", lo_o, 32'd0);
    check("arst_nocommit_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 150; i++) begin
      int          o;
      logic [31:0] a, b;
      o = int'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = a & 32'hFF; b = b & 32'hF; end
        3: b = -(b & 32'hFF);
        default: ;
      endcase
      do_op(o, a, b);
      if ((i % 10) == 0) check_out();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
